// File: rtl/axil_host_master.sv
// AXI4-Lite host master: runs one register read or write per command, with a per-channel
// handshake timeout. Also holds a GPIO output register and a 2-flop GPIO input synchronizer
// with a rising-edge IRQ detector on input bit 0.
//
// Ports:
//   aclk, aclk_reset           clock and synchronous active-high reset
//   cmd_*                      command request (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*                      one-cycle completion pulse with rdata, resp and timeout flag
//   m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite master channels
//   gpio_wr, gpio_wdata        load the GPIO output register
//   gpio_out                   registered GPIO outputs
//   gpio_in                    asynchronous GPIO inputs
//   gpio_in_sync               synchronized GPIO inputs
//   irq_rise                   one-cycle pulse on a rising edge of gpio_in_sync[0]
module axil_host_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned NUMB_INPUT_IO  = 1,
  parameter int unsigned NUMB_OUTPUT_IO = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aclk_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic                      gpio_wr,
  input  logic [NUMB_OUTPUT_IO-1:0] gpio_wdata,
  output logic [NUMB_OUTPUT_IO-1:0] gpio_out,
  input  logic [NUMB_INPUT_IO-1:0]  gpio_in,
  output logic [NUMB_INPUT_IO-1:0]  gpio_in_sync,
  output logic                      irq_rise
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value seen in the last allowed wait cycle of a state.
  localparam logic [CntW-1:0] CntMax =
      CntW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWr     = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdAddr = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  aw_done, w_done, abort, timeout_hit;

  logic [NUMB_OUTPUT_IO-1:0] gpio_out_q;
  logic [NUMB_INPUT_IO-1:0]  sync1_q, sync2_q;
  logic                      sync_d0_q;
  logic                      irq_rise_q;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntMax);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    aw_done       = 1'b0;
    w_done        = 1'b0;
    abort         = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWr: begin
        // A channel counts as done if it already handshook or handshakes this cycle.
        aw_done   = !awvalid_q || m_awready;
        w_done    = !wvalid_q || m_wready;
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (aw_done && w_done) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrResp: begin
        if (m_bvalid) begin
          state_d       = StIdle;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_bresp;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdAddr: begin
        if (m_arready) begin
          state_d   = StRdData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdData: begin
        if (m_rvalid) begin
          state_d       = StIdle;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_rdata;
          rsp_resp_d    = m_rresp;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d       = StIdle;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end

    // Registered so the accept window opens in the same cycle as the response pulse.
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_d0_q  <= 1'b0;
      irq_rise_q <= 1'b0;
    end else begin
      if (gpio_wr) gpio_out_q <= gpio_wdata;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      sync_d0_q  <= sync2_q[0];
      irq_rise_q <= sync2_q[0] & ~sync_d0_q;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign m_awaddr     = addr_q;
  assign m_awprot     = 3'b000;
  assign m_awvalid    = awvalid_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = wstrb_q;
  assign m_wvalid     = wvalid_q;
  assign m_bready     = bready_q;
  assign m_araddr     = addr_q;
  assign m_arprot     = 3'b000;
  assign m_arvalid    = arvalid_q;
  assign m_rready     = rready_q;
  assign gpio_out     = gpio_out_q;
  assign gpio_in_sync = sync2_q;
  assign irq_rise     = irq_rise_q;

endmodule

// File: tb/tb_axil_host_master.sv
`timescale 1ns/1ps
module tb_axil_host_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [10:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [10:0] m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0, m_bready;
  logic        m_arvalid, m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0, m_rready;
  logic        gpio_wr = 1'b0;
  logic [2:0]  gpio_wdata = '0, gpio_out;
  logic [0:0]  gpio_in = '0, gpio_in_sync;
  logic        irq_rise;

  int checks = 0, failures = 0;
  int rsp_cnt = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int exp_rsp = 0, exp_aw = 0, exp_w = 0, exp_ar = 0;
  int last_wait = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];

  axil_host_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .NUMB_INPUT_IO(1), .NUMB_OUTPUT_IO(3),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(clk), .aclk_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .gpio_wr(gpio_wr), .gpio_wdata(gpio_wdata), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync), .irq_rise(irq_rise)
  );

  always #5 clk = ~clk;

  // Handshake and response counters, sampled at the edge where they take effect.
  always @(posedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    if (m_awvalid === 1'b1 && m_awready === 1'b1) aw_cnt <= aw_cnt + 1;
    if (m_wvalid === 1'b1 && m_wready === 1'b1) w_cnt <= w_cnt + 1;
    if (m_arvalid === 1'b1 && m_arready === 1'b1) ar_cnt <= ar_cnt + 1;
  end

  task automatic send_cmd(input logic wr, input logic [10:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    last_wait = n;
    checks++;
    if (n >= 50) begin failures++; $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  task automatic aw_chan(input int dly, output logic [10:0] a_seen);
    int n = 0;
    while (m_awvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL awvalid_wait: awvalid=%b required 1", m_awvalid); end
    repeat (dly) begin
      @(negedge clk); checks++;
      if (m_awvalid !== 1'b1) begin failures++; $display("FAIL awvalid_hold: awvalid=%b required 1", m_awvalid); end
    end
    a_seen = m_awaddr;
    checks++;
    if (m_awprot !== 3'b000) begin failures++; $display("FAIL awprot: got %b required 000", m_awprot); end
    m_awready = 1'b1;
    @(negedge clk);
    m_awready = 1'b0;
    checks++;
    if (m_awvalid !== 1'b0) begin failures++; $display("FAIL awvalid_drop: awvalid=%b required 0", m_awvalid); end
  endtask

  task automatic w_chan(input int dly, output logic [31:0] d_seen, output logic [3:0] s_seen);
    int n = 0;
    while (m_wvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL wvalid_wait: wvalid=%b required 1", m_wvalid); end
    repeat (dly) begin
      @(negedge clk); checks++;
      if (m_wvalid !== 1'b1) begin failures++; $display("FAIL wvalid_hold: wvalid=%b required 1", m_wvalid); end
    end
    d_seen = m_wdata; s_seen = m_wstrb;
    m_wready = 1'b1;
    @(negedge clk);
    m_wready = 1'b0;
    checks++;
    if (m_wvalid !== 1'b0) begin failures++; $display("FAIL wvalid_drop: wvalid=%b required 0", m_wvalid); end
  endtask

  task automatic b_chan(input int dly, input logic [1:0] resp);
    int n = 0;
    while (m_bready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL bready_wait: bready=%b required 1", m_bready); end
    repeat (dly) begin
      @(negedge clk); checks++;
      if (m_bready !== 1'b1) begin failures++; $display("FAIL bready_hold: bready=%b required 1", m_bready); end
    end
    m_bvalid = 1'b1; m_bresp = resp;
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic ar_chan(input int dly, output logic [10:0] a_seen);
    int n = 0;
    while (m_arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL arvalid_wait: arvalid=%b required 1", m_arvalid); end
    repeat (dly) begin
      @(negedge clk); checks++;
      if (m_arvalid !== 1'b1) begin failures++; $display("FAIL arvalid_hold: arvalid=%b required 1", m_arvalid); end
    end
    a_seen = m_araddr;
    checks++;
    if (m_arprot !== 3'b000) begin failures++; $display("FAIL arprot: got %b required 000", m_arprot); end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    checks++;
    if (m_arvalid !== 1'b0) begin failures++; $display("FAIL arvalid_drop: arvalid=%b required 0", m_arvalid); end
  endtask

  task automatic r_chan(input int dly, input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    while (m_rready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL rready_wait: rready=%b required 1", m_rready); end
    repeat (dly) begin
      @(negedge clk); checks++;
      if (m_rready !== 1'b1) begin failures++; $display("FAIL rready_hold: rready=%b required 1", m_rready); end
    end
    m_rvalid = 1'b1; m_rdata = data; m_rresp = resp;
    @(negedge clk);
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  task automatic model_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [10:0] a_seen, input logic [31:0] d_seen,
                             input logic [3:0] s_seen);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      if (s_seen[b]) slv_mem[a_seen[5:2]][8*b +: 8] = d_seen[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] resp);
    logic [10:0] a_seen;
    logic [31:0] d_seen;
    logic [3:0]  s_seen;
    send_cmd(1'b1, a, d, s);
    fork
      aw_chan(aw_dly, a_seen);
      w_chan(w_dly, d_seen, s_seen);
    join
    checks++;
    if (a_seen !== a) begin failures++; $display("FAIL wr_awaddr: got %h required %h", a_seen, a); end
    checks++;
    if (d_seen !== d || s_seen !== s) begin
      failures++; $display("FAIL wr_wdata: got %h/%h required %h/%h", d_seen, s_seen, d, s);
    end
    model_write(a, d, s, a_seen, d_seen, s_seen);
    b_chan(b_dly, resp);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== resp || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp: valid=%b resp=%b rdata=%h tmo=%b required 1/%b/0/0",
               rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, resp);
    end
    checks++;
    if (m_bready !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL wr_done: bready=%b cmd_ready=%b required 0/1", m_bready, cmd_ready);
    end
    exp_rsp++; exp_aw++; exp_w++;
  endtask

  task automatic do_read(input logic [10:0] a, input int ar_dly, input int r_dly,
                         input logic [1:0] resp);
    logic [10:0] a_seen;
    logic [31:0] exp_d;
    exp_d = ref_mem[a[5:2]];
    send_cmd(1'b0, a, 32'h0, 4'h0);
    ar_chan(ar_dly, a_seen);
    checks++;
    if (a_seen !== a) begin failures++; $display("FAIL rd_araddr: got %h required %h", a_seen, a); end
    r_chan(r_dly, slv_mem[a_seen[5:2]], resp);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== resp || rsp_rdata !== exp_d || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rd_rsp: valid=%b resp=%b rdata=%h tmo=%b required 1/%b/%h/0",
               rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, resp, exp_d);
    end
    checks++;
    if (m_rready !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rd_done: rready=%b cmd_ready=%b required 0/1", m_rready, cmd_ready);
    end
    exp_rsp++; exp_ar++;
  endtask

  task automatic check_timeout_rsp(input string name, input int n);
    checks++;
    if (n !== TMO) begin failures++; $display("FAIL %s_len: held %0d cycles required %0d", name, n, TMO); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL %s_rsp: valid=%b tmo=%b resp=%b rdata=%h required 1/1/10/0",
               name, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
    end
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0 || m_arvalid !== 1'b0 ||
        m_rready !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL %s_idle: handshake outputs not idle after timeout", name);
    end
    exp_rsp++;
  endtask

  task automatic test_reset();
    rst = 1'b1; gpio_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b00 ||
        rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_cmd_rsp: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0 || m_arvalid !== 1'b0 ||
        m_rready !== 1'b0) begin
      failures++; $display("FAIL reset_axi: aw=%b w=%b b=%b ar=%b r=%b required 0",
                           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready);
    end
    checks++;
    if (gpio_out !== 3'b000 || gpio_in_sync !== 1'b0 || irq_rise !== 1'b0) begin
      failures++; $display("FAIL reset_gpio: out=%b sync=%b irq=%b required 0", gpio_out, gpio_in_sync, irq_rise);
    end
    gpio_in = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_idle: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    do_write(11'h010, 32'h12345678, 4'hF, 0, 0, 0, 2'b00);
  endtask

  task automatic test_read_basic();
    ref_mem[4] = 32'hCAFEF00D; slv_mem[4] = 32'hCAFEF00D;
    do_read(11'h010, 0, 3, 2'b00);
  endtask

  task automatic test_write_skew();
    do_write(11'h024, $urandom, 4'($urandom), 0, 2, 0, 2'b00);
    do_write(11'h038, $urandom, 4'($urandom), 3, 0, 1, 2'b10);
    do_read(11'h024, 1, 0, 2'b00);
    do_read(11'h038, 0, 2, 2'b01);
  endtask

  task automatic test_back_to_back();
    do_write(11'h004, 32'hA5A55A5A, 4'b0101, 0, 0, 0, 2'b00);
    do_read(11'h004, 0, 0, 2'b00);
    checks++;
    if (last_wait !== 0) begin failures++; $display("FAIL b2b_accept_rd: waited %0d required 0", last_wait); end
    do_write(11'h004, 32'h0F0F0F0F, 4'b1010, 0, 0, 0, 2'b00);
    checks++;
    if (last_wait !== 0) begin failures++; $display("FAIL b2b_accept_wr: waited %0d required 0", last_wait); end
    do_read(11'h004, 0, 0, 2'b00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [10:0] a;
      a = {5'($urandom), 4'($urandom), 2'b00};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), 2'($urandom));
      else
        do_read(a, $urandom_range(0, 5), $urandom_range(0, 5), 2'($urandom));
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [10:0] a_seen;
    logic [31:0] d_seen;
    logic [3:0]  s_seen;
    send_cmd(1'b0, 11'h010, 32'h0, 4'h0);
    n = 0;
    while (m_arvalid === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check_timeout_rsp("tmo_ar", n);
    send_cmd(1'b1, 11'h020, 32'hDEADBEEF, 4'hF);
    fork
      aw_chan(0, a_seen);
      w_chan(0, d_seen, s_seen);
    join
    model_write(11'h020, 32'hDEADBEEF, 4'hF, a_seen, d_seen, s_seen);
    exp_aw++; exp_w++;
    n = 0;
    while (m_bready === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check_timeout_rsp("tmo_b", n);
    do_read(11'h020, 0, 0, 2'b00);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [10:0] a_seen;
    logic [31:0] d_seen;
    logic [3:0]  s_seen;
    send_cmd(1'b1, 11'h030, 32'h13572468, 4'hF);
    fork
      aw_chan(0, a_seen);
      w_chan(0, d_seen, s_seen);
    join
    model_write(11'h030, 32'h13572468, 4'hF, a_seen, d_seen, s_seen);
    exp_aw++; exp_w++;
    while (m_bready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_bready !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid: bready=%b cmd_ready=%b rsp_valid=%b required 0/1/0",
                           m_bready, cmd_ready, rsp_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_rsp: rsp_valid=%b required 0", rsp_valid); end
    end
    do_read(11'h030, 0, 1, 2'b00);
  endtask

  task automatic test_gpio();
    logic [2:0] v;
    int pulses;
    gpio_wr = 1'b1; gpio_wdata = 3'b101;
    @(negedge clk);
    gpio_wr = 1'b0; gpio_wdata = 3'b010;
    checks++;
    if (gpio_out !== 3'b101) begin failures++; $display("FAIL gpio_load: got %b required 101", gpio_out); end
    @(negedge clk);
    checks++;
    if (gpio_out !== 3'b101) begin failures++; $display("FAIL gpio_hold: got %b required 101", gpio_out); end
    for (int i = 0; i < 4; i++) begin
      v = 3'($urandom);
      gpio_wr = 1'b1; gpio_wdata = v;
      @(negedge clk);
      gpio_wr = 1'b0; gpio_wdata = ~v;
      checks++;
      if (gpio_out !== v) begin failures++; $display("FAIL gpio_rand: got %b required %b", gpio_out, v); end
    end
    gpio_in = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); checks++;
      if (irq_rise !== (c == 3)) begin
        failures++; $display("FAIL irq_latency: cycle %0d irq=%b required %b", c, irq_rise, (c == 3));
      end
    end
    checks++;
    if (gpio_in_sync !== 1'b1) begin failures++; $display("FAIL gpio_sync: got %b required 1", gpio_in_sync); end
    gpio_in = 1'b0;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (irq_rise === 1'b1) pulses++; end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL irq_fall: %0d pulses required 0", pulses); end
    gpio_in = 1'b1;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (irq_rise === 1'b1) pulses++; end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL irq_once: %0d pulses required 1", pulses); end
  endtask

  task automatic test_counts();
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_cnt !== exp_rsp) begin failures++; $display("FAIL rsp_count: got %0d required %0d", rsp_cnt, exp_rsp); end
    checks++;
    if (aw_cnt !== exp_aw || w_cnt !== exp_w) begin
      failures++; $display("FAIL wr_hs_count: aw=%0d w=%0d required %0d/%0d", aw_cnt, w_cnt, exp_aw, exp_w);
    end
    checks++;
    if (ar_cnt !== exp_ar) begin failures++; $display("FAIL ar_hs_count: got %0d required %0d", ar_cnt, exp_ar); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_skew();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    test_gpio();
    test_counts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
